// File: rtl/aoc4_pkg.sv
// Shared types and widths for the AOC4 grid-pruning scheduler.
package aoc4_pkg;
    localparam int PASS_CNT_W      = 8;
    localparam int BANK_ADDR_WIDTH = 8;
    localparam int COL_ADDR_WIDTH  = 8;
    localparam int TX_DATA_WIDTH   = 8;

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, CHECK, FIN} sched_state_t;
    typedef enum logic {B_IDLE, B_REQ} bus_state_t;
endpackage

// File: rtl/freemachine_sched_if.sv
// Worker-side and memory-side bus bundle of the freemachine pass scheduler.
interface freemachine_sched_if
    import aoc4_pkg::*;
#(
    parameter int N_WORKERS = 4
);
    logic [N_WORKERS-1:0]                 wk_run;
    logic [N_WORKERS-1:0]                 wk_read_en;
    logic [N_WORKERS-1:0]                 wk_write_en;
    logic [N_WORKERS*BANK_ADDR_WIDTH-1:0] wk_row_addr;
    logic [N_WORKERS*COL_ADDR_WIDTH-1:0]  wk_col_addr;
    logic [N_WORKERS*TX_DATA_WIDTH-1:0]   wk_wdata;
    logic [N_WORKERS-1:0]                 wk_changed;
    logic [N_WORKERS-1:0]                 wk_done;
    logic [N_WORKERS-1:0]                 wk_ack;
    logic [TX_DATA_WIDTH-1:0]             wk_rdata;

    logic                                 mem_req_out;
    logic                                 mem_we_out;
    logic [BANK_ADDR_WIDTH-1:0]           mem_row_addr_out;
    logic [COL_ADDR_WIDTH-1:0]            mem_col_addr_out;
    logic [TX_DATA_WIDTH-1:0]             mem_wdata_out;
    logic [TX_DATA_WIDTH-1:0]             mem_rdata_in;
    logic                                 mem_ack_in;

    // The scheduler is the master of the shared memory bank.
    modport master (
        output wk_run, wk_ack, wk_rdata,
        output mem_req_out, mem_we_out, mem_row_addr_out, mem_col_addr_out, mem_wdata_out,
        input  wk_read_en, wk_write_en, wk_row_addr, wk_col_addr, wk_wdata,
        input  wk_changed, wk_done, mem_rdata_in, mem_ack_in
    );

    modport slave (
        input  wk_run, wk_ack, wk_rdata,
        input  mem_req_out, mem_we_out, mem_row_addr_out, mem_col_addr_out, mem_wdata_out,
        output wk_read_en, wk_write_en, wk_row_addr, wk_col_addr, wk_wdata,
        output wk_changed, wk_done, mem_rdata_in, mem_ack_in
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);
    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end
endmodule

// File: rtl/freemachine_sched.sv
// Pass scheduler for the freemachine worker bank plus round-robin arbiter
// for the single-port grid memory shared by all workers.
module freemachine_sched
    import aoc4_pkg::*;
#(
    parameter int N_WORKERS  = 4,
    parameter int MAX_PASSES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [PASS_CNT_W-1:0] pass_count,
    freemachine_sched_if.master   bus
);
    localparam int IDX_W = $clog2(N_WORKERS);
    localparam logic [PASS_CNT_W-1:0] PASS_LIMIT = PASS_CNT_W'(MAX_PASSES);

    sched_state_t         state, state_next;
    bus_state_t           bstate, bstate_next;
    logic                 sticky, first_run;
    logic [N_WORKERS-1:0] req, arb_grant, grant_oh;
    logic [IDX_W-1:0]     arb_idx, grant_idx, rr_ptr;

    assign req          = bus.wk_read_en | bus.wk_write_en;
    assign bus.wk_rdata = bus.mem_rdata_in;

    rr_arbiter #(.N(N_WORKERS)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Workers clear done on run, so done is ignored in the first RUN cycle.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == FIN);
        bus.wk_run = {N_WORKERS{state == LAUNCH}};
        case (state)
            IDLE:    if (start) state_next = LAUNCH;
            LAUNCH:  state_next = RUN;
            RUN:     if (!first_run && (&bus.wk_done) && bstate == B_IDLE) state_next = CHECK;
            CHECK:   state_next = (sticky && pass_count < PASS_LIMIT) ? LAUNCH : FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky     <= 1'b0;
            first_run  <= 1'b0;
            pass_count <= '0;
            converged  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pass_count <= '0;
                    converged  <= 1'b0;
                    sticky     <= 1'b0;
                end
                LAUNCH: begin
                    sticky    <= 1'b0;
                    first_run <= 1'b1;
                end
                RUN: begin
                    sticky    <= sticky | (|bus.wk_changed);
                    first_run <= 1'b0;
                    if (state_next == CHECK && pass_count < PASS_LIMIT)
                        pass_count <= pass_count + 1'b1;
                end
                CHECK: if (state_next == FIN) converged <= ~sticky;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) bstate <= B_IDLE;
        else       bstate <= bstate_next;
    end

    always_comb begin
        bstate_next = bstate;
        bus.wk_ack  = '0;
        case (bstate)
            B_IDLE: if (|req) bstate_next = B_REQ;
            B_REQ: if (bus.mem_ack_in) begin
                bstate_next = B_IDLE;
                bus.wk_ack  = grant_oh;
            end
            default: bstate_next = B_IDLE;
        endcase
    end

    // Grant is captured once per transfer and held until the memory acks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_oh             <= '0;
            grant_idx            <= '0;
            rr_ptr               <= '0;
            bus.mem_req_out      <= 1'b0;
            bus.mem_we_out       <= 1'b0;
            bus.mem_row_addr_out <= '0;
            bus.mem_col_addr_out <= '0;
            bus.mem_wdata_out    <= '0;
        end else if (bstate == B_IDLE && (|req)) begin
            grant_oh             <= arb_grant;
            grant_idx            <= arb_idx;
            bus.mem_req_out      <= 1'b1;
            bus.mem_we_out       <= bus.wk_write_en[arb_idx];
            bus.mem_row_addr_out <= bus.wk_row_addr[arb_idx*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
            bus.mem_col_addr_out <= bus.wk_col_addr[arb_idx*COL_ADDR_WIDTH +: COL_ADDR_WIDTH];
            bus.mem_wdata_out    <= bus.wk_wdata[arb_idx*TX_DATA_WIDTH +: TX_DATA_WIDTH];
        end else if (bstate == B_REQ && bus.mem_ack_in) begin
            bus.mem_req_out <= 1'b0;
            rr_ptr          <= (grant_idx == IDX_W'(N_WORKERS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_freemachine_sched.sv
// Directed bench for freemachine_sched: 4 workers, pass limit of 3.
module tb_freemachine_sched;
    import aoc4_pkg::*;

    logic                  clock;
    logic                  reset;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  converged;
    logic [PASS_CNT_W-1:0] pass_count;

    int tests = 0;
    int fails = 0;
    int run_pulses = 0;
    int base;
    logic proto_err = 1'b0;

    freemachine_sched_if #(.N_WORKERS(4)) bus ();

    freemachine_sched #(.N_WORKERS(4), .MAX_PASSES(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .pass_count (pass_count),
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.wk_run != '0) run_pulses++;
        if (bus.mem_req_out && ((bus.wk_read_en | bus.wk_write_en) == '0)) proto_err = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Entered in the LAUNCH cycle; returns in the CHECK cycle.
    task automatic run_pass(input logic [3:0] chg, input int len, input logic [7:0] exp_cnt);
        chk("launch_wk_run", bus.wk_run, 4'hF);
        tick();
        bus.wk_done    = 4'hC;
        bus.wk_changed = chg;
        start          = 1'b1;
        tick();
        bus.wk_changed = 4'h0;
        start          = 1'b0;
        chk("start_ignored_busy", bus.wk_run, 4'h0);
        repeat (len) tick();
        chk("busy_in_run", busy, 1'b1);
        bus.wk_done = 4'hF;
        tick();
        chk("pass_count", pass_count, exp_cnt);
        chk("done_low_check", done, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.wk_read_en   = '0;
        bus.wk_write_en  = '0;
        bus.wk_row_addr  = '0;
        bus.wk_col_addr  = '0;
        bus.wk_wdata     = '0;
        bus.wk_changed   = '0;
        bus.wk_done      = 4'hF;
        bus.mem_rdata_in = '0;
        bus.mem_ack_in   = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_converged", converged, 1'b0);
        chk("rst_pass_count", pass_count, 8'd0);
        chk("rst_wk_run", bus.wk_run, 4'h0);
        chk("rst_mem_req", bus.mem_req_out, 1'b0);
        chk("rst_mem_we", bus.mem_we_out, 1'b0);
        chk("rst_mem_row", bus.mem_row_addr_out, 8'd0);
        chk("rst_mem_col", bus.mem_col_addr_out, 8'd0);
        chk("rst_mem_wdata", bus.mem_wdata_out, 8'd0);
        chk("rst_wk_ack", bus.wk_ack, 4'h0);

        // Round robin: all four read continuously, row address = worker + 1.
        reset           = 1'b0;
        bus.wk_row_addr = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.wk_read_en  = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_req", bus.mem_req_out, 1'b1);
            chk("rr_row", bus.mem_row_addr_out, 32'((k % 4) + 1));
            chk("rr_no_ack_early", bus.wk_ack, 4'h0);
            tick();
            chk("rr_row_held", bus.mem_row_addr_out, 32'((k % 4) + 1));
            bus.mem_ack_in = 1'b1;
            #1;
            chk("rr_ack", bus.wk_ack, 32'(1 << (k % 4)));
            tick();
            bus.mem_ack_in = 1'b0;
            chk("rr_req_drop", bus.mem_req_out, 1'b0);
        end

        // Write priority and routing from worker 2.
        bus.wk_read_en  = 4'b0100;
        bus.wk_write_en = 4'b0100;
        bus.wk_row_addr = {8'd4, 8'd5, 8'd2, 8'd1};
        bus.wk_col_addr = {8'd0, 8'd8, 8'd0, 8'd0};
        bus.wk_wdata    = {8'h00, 8'hA5, 8'h00, 8'h00};
        tick();
        chk("wr_req", bus.mem_req_out, 1'b1);
        chk("wr_we", bus.mem_we_out, 1'b1);
        chk("wr_row", bus.mem_row_addr_out, 8'd5);
        chk("wr_col", bus.mem_col_addr_out, 8'd8);
        chk("wr_wdata", bus.mem_wdata_out, 8'hA5);
        bus.mem_rdata_in = 8'h3C;
        bus.mem_ack_in   = 1'b1;
        #1;
        chk("wr_ack", bus.wk_ack, 4'b0100);
        chk("rdata_pass", bus.wk_rdata, 8'h3C);
        tick();
        bus.mem_ack_in  = 1'b0;
        bus.wk_read_en  = '0;
        bus.wk_write_en = '0;
        chk("wr_req_drop", bus.mem_req_out, 1'b0);
        bus.wk_row_addr = {8'd4, 8'd3, 8'd2, 8'd1};

        // Converges in two passes.
        start = 1'b1;
        tick();
        start = 1'b0;
        base  = run_pulses;
        chk("cv_busy", busy, 1'b1);
        chk("cv_pass_clear", pass_count, 8'd0);
        run_pass(4'b0001, 16, 8'd1);
        tick();
        run_pass(4'b0000, 4, 8'd2);
        tick();
        chk("cv_done", done, 1'b1);
        chk("cv_converged", converged, 1'b1);
        chk("cv_pass_count", pass_count, 8'd2);
        chk("cv_busy_at_done", busy, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cv_done_pulse", done, 1'b0);
        chk("cv_busy_fall", busy, 1'b0);
        chk("cv_converged_hold", converged, 1'b1);
        chk("cv_start_at_done_ignored", bus.wk_run, 4'h0);
        tick();
        chk("cv_still_idle", busy, 1'b0);
        chk("cv_run_pulses", 32'(run_pulses - base), 32'd2);

        // Pass limit: a worker changes every pass.
        start = 1'b1;
        tick();
        start = 1'b0;
        base  = run_pulses;
        chk("pl_converged_clear", converged, 1'b0);
        run_pass(4'b0010, 3, 8'd1);
        tick();
        run_pass(4'b0001, 3, 8'd2);
        tick();
        run_pass(4'b0011, 3, 8'd3);
        tick();
        chk("pl_done", done, 1'b1);
        chk("pl_pass_count", pass_count, 8'd3);
        chk("pl_converged", converged, 1'b0);
        tick();
        chk("pl_busy_fall", busy, 1'b0);
        chk("pl_pass_sat", pass_count, 8'd3);
        chk("pl_run_pulses", 32'(run_pulses - base), 32'd3);

        // Async reset in the middle of a stalled transfer.
        bus.wk_read_en = 4'b0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ar_req", bus.mem_req_out, 1'b1);
        chk("ar_row", bus.mem_row_addr_out, 8'd2);
        tick();
        chk("ar_req_held", bus.mem_req_out, 1'b1);
        #1;
        reset          = 1'b1;
        bus.mem_ack_in = 1'b1;
        #1;
        chk("ar_req_drop", bus.mem_req_out, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_wk_run", bus.wk_run, 4'h0);
        chk("ar_row_clear", bus.mem_row_addr_out, 8'd0);
        chk("ar_no_ack", bus.wk_ack, 4'h0);
        reset          = 1'b0;
        bus.mem_ack_in = 1'b0;
        bus.wk_read_en = '0;
        bus.wk_done    = 4'hF;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ar_restart_busy", busy, 1'b1);
        run_pass(4'b0000, 2, 8'd1);
        tick();
        chk("ar_restart_done", done, 1'b1);
        chk("ar_restart_converged", converged, 1'b1);
        tick();

        // rr pointer must be back at 0 after reset: workers 0 and 3 contend.
        bus.wk_read_en = 4'b1001;
        tick();
        chk("ar_rr_reset", bus.mem_row_addr_out, 8'd1);
        bus.mem_ack_in = 1'b1;
        tick();
        bus.mem_ack_in = 1'b0;
        bus.wk_read_en = '0;
        tick();

        chk("protocol_hold", proto_err, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
